// File: rtl/p405s_mul_pass_seq.sv
// Pass sequencer for the 405 execute-stage 32x16 multiplier array (one or two 16-bit passes over B).
// Optional early-out on a redundant B high half is enabled by defining P405S_MUL_EARLY_OUT_EN.
module p405s_mul_pass_seq #(
  parameter int unsigned PASS_CYC = 2
) (
  input  logic       CB,
  input  logic       rstN,
  input  logic       mulStart,
  input  logic [1:0] mulOp,
  input  logic       mulSigned,
  input  logic       bBytes01Eq0,
  input  logic       bBytes01Eq1,
  input  logic       bBit16,
  input  logic       exeFlush,
  input  logic       wbHold,
  output logic       mulBusy,
  output logic       mulPassSel,
  output logic       mulAccClr,
  output logic       mulAccEn,
  output logic       mulShift16,
  output logic       mulHiSigned,
  output logic       mulDone,
  output logic       mulEarlyOut
);

  typedef enum logic [1:0] {IDLE, PASS0, PASS1, FIN} state_t;

  localparam logic [1:0] LAST = 2'(PASS_CYC - 1);

  state_t     state, state_d;
  logic [1:0] cnt, cnt_d;
  logic       early_q, early_d;
  logic       sgn_q, sgn_d;
  logic       early_in;
  logic       last;

`ifdef P405S_MUL_EARLY_OUT_EN
  // High-word results always need the full second pass, so early-out only applies to mullw.
  always_comb begin
    if (mulOp == 2'b01 || mulOp == 2'b10)
      early_in = 1'b0;
    else if (mulSigned)
      early_in = (bBytes01Eq0 & ~bBit16) | (bBytes01Eq1 & bBit16);
    else
      early_in = bBytes01Eq0;
  end
`else
  logic unused_early_in;
  assign unused_early_in = bBytes01Eq0 ^ bBytes01Eq1 ^ bBit16;
  assign early_in = 1'b0;
`endif

  assign last = (cnt == LAST);

  always_ff @(posedge CB or negedge rstN) begin
    if (!rstN) begin
      state   <= IDLE;
      cnt     <= '0;
      early_q <= 1'b0;
      sgn_q   <= 1'b0;
    end else begin
      state   <= state_d;
      cnt     <= cnt_d;
      early_q <= early_d;
      sgn_q   <= sgn_d;
    end
  end

  always_comb begin
    state_d     = state;
    cnt_d       = cnt;
    early_d     = early_q;
    sgn_d       = sgn_q;
    mulBusy     = 1'b0;
    mulPassSel  = 1'b0;
    mulAccClr   = 1'b0;
    mulAccEn    = 1'b0;
    mulShift16  = 1'b0;
    mulHiSigned = 1'b0;
    mulDone     = 1'b0;
    mulEarlyOut = 1'b0;
    case (state)
      IDLE: begin
        if (mulStart && !exeFlush) begin
          state_d = PASS0;
          cnt_d   = '0;
          early_d = early_in;
          sgn_d   = mulSigned;
        end
      end
      PASS0: begin
        mulBusy     = 1'b1;
        mulEarlyOut = early_q;
        mulAccClr   = (cnt == '0);
        mulAccEn    = last & ~exeFlush;
        if (last) begin
          cnt_d   = '0;
          state_d = early_q ? FIN : PASS1;
        end else begin
          cnt_d = cnt + 2'd1;
        end
      end
      PASS1: begin
        mulBusy     = 1'b1;
        mulEarlyOut = early_q;
        mulPassSel  = 1'b1;
        mulShift16  = 1'b1;
        mulHiSigned = sgn_q;
        mulAccEn    = last & ~exeFlush;
        if (last) begin
          cnt_d   = '0;
          state_d = FIN;
        end else begin
          cnt_d = cnt + 2'd1;
        end
      end
      FIN: begin
        mulBusy     = 1'b1;
        mulEarlyOut = early_q;
        mulDone     = ~exeFlush;
        if (!wbHold) begin
          state_d = IDLE;
          early_d = 1'b0;
          sgn_d   = 1'b0;
        end
      end
      default: state_d = IDLE;
    endcase
    // A kill overrides every transition above, including a held FIN.
    if (exeFlush && state != IDLE) begin
      state_d = IDLE;
      cnt_d   = '0;
      early_d = 1'b0;
      sgn_d   = 1'b0;
    end
  end

endmodule

// File: tb/tb_p405s_mul_pass_seq.sv
// Directed bench for p405s_mul_pass_seq with a cycle-count schedule model checked every cycle.
`timescale 1ns/1ps
module tb_p405s_mul_pass_seq;

  localparam int P = 2;
`ifdef P405S_MUL_EARLY_OUT_EN
  localparam bit EO = 1'b1;
`else
  localparam bit EO = 1'b0;
`endif

  logic CB = 1'b0;
  logic rstN = 1'b0;
  logic mulStart = 1'b0, mulSigned = 1'b0, bBytes01Eq0 = 1'b0, bBytes01Eq1 = 1'b0;
  logic bBit16 = 1'b0, exeFlush = 1'b0, wbHold = 1'b0;
  logic [1:0] mulOp = 2'b00;
  logic mulBusy, mulPassSel, mulAccClr, mulAccEn, mulShift16, mulHiSigned, mulDone, mulEarlyOut;

  int tests = 0;
  int fails = 0;

  p405s_mul_pass_seq #(.PASS_CYC(P)) dut (
    .CB(CB), .rstN(rstN), .mulStart(mulStart), .mulOp(mulOp), .mulSigned(mulSigned),
    .bBytes01Eq0(bBytes01Eq0), .bBytes01Eq1(bBytes01Eq1), .bBit16(bBit16),
    .exeFlush(exeFlush), .wbHold(wbHold), .mulBusy(mulBusy), .mulPassSel(mulPassSel),
    .mulAccClr(mulAccClr), .mulAccEn(mulAccEn), .mulShift16(mulShift16),
    .mulHiSigned(mulHiSigned), .mulDone(mulDone), .mulEarlyOut(mulEarlyOut)
  );

  always #5 CB = ~CB;

  // Model: an active multiply is k cycles old; the first npass*P cycles are array passes, then FIN.
  bit m_act = 0;
  int m_k = 0;
  int m_npass = 2;
  bit m_early = 0;
  bit m_sgn = 0;

  function automatic bit model_early(input logic [1:0] op, input logic sgn, input logic eq0,
                                     input logic eq1, input logic b16);
    if (!EO || op == 2'b01 || op == 2'b10) return 1'b0;
    if (sgn) return (eq0 && !b16) || (eq1 && b16);
    return eq0;
  endfunction

  always @(posedge CB or negedge rstN) begin
    if (!rstN) begin
      m_act = 0; m_k = 0; m_early = 0; m_sgn = 0;
    end else if (!m_act) begin
      if (mulStart && !exeFlush) begin
        m_act = 1; m_k = 0;
        m_early = model_early(mulOp, mulSigned, bBytes01Eq0, bBytes01Eq1, bBit16);
        m_sgn = mulSigned;
        m_npass = m_early ? 1 : 2;
      end
    end else if (exeFlush) begin
      m_act = 0; m_early = 0; m_sgn = 0;
    end else if (m_k < m_npass * P) begin
      m_k = m_k + 1;
    end else if (!wbHold) begin
      m_act = 0; m_early = 0; m_sgn = 0;
    end
  end

  // {busy, passSel, accClr, accEn, shift16, hiSigned, done, earlyOut}
  function automatic logic [7:0] model_outs();
    int pass, sub;
    if (!m_act) return 8'h00;
    if (m_k < m_npass * P) begin
      pass = m_k / P;
      sub  = m_k % P;
      return {1'b1, pass == 1, m_k == 0, (sub == P - 1) && !exeFlush, pass == 1,
              (pass == 1) && m_sgn, 1'b0, m_early};
    end
    return {1'b1, 1'b0, 1'b0, 1'b0, 1'b0, 1'b0, !exeFlush, m_early};
  endfunction

  always @(negedge CB) begin
    logic [7:0] got, exp;
    got = {mulBusy, mulPassSel, mulAccClr, mulAccEn, mulShift16, mulHiSigned, mulDone, mulEarlyOut};
    exp = model_outs();
    tests++;
    if (got !== exp) begin
      fails++;
      $display("FAIL cycle_outputs t=%0t got=%b exp=%b", $time, got, exp);
    end
  end

  task automatic chk(input string name, input int got, input int exp);
    tests++;
    if (got != exp) begin
      fails++;
      $display("FAIL %s got=%0d exp=%0d", name, got, exp);
    end
  endtask

  task automatic tick();
    @(posedge CB);
    #1;
  endtask

  int r_first, r_done, r_en, r_sel, r_hs, r_eo, r_end;

  // Starts one op at the next edge, then walks cycles 1.. (cycle 1 follows the start edge).
  task automatic run_op(input logic [1:0] op, input logic sgn, input logic eq0, input logic eq1,
                        input logic b16, input int repulse, input int hold_lo, input int hold_hi,
                        input int flush_at);
    mulStart = 1; mulOp = op; mulSigned = sgn;
    bBytes01Eq0 = eq0; bBytes01Eq1 = eq1; bBit16 = b16;
    tick();
    r_first = 0; r_done = 0; r_en = 0; r_sel = 0; r_hs = 0; r_eo = 0; r_end = 0;
    for (int c = 1; c <= 30; c++) begin
      mulStart = (c == repulse);
      wbHold   = (c >= hold_lo) && (c <= hold_hi);
      exeFlush = (c == flush_at);
      #1;
      if (!mulBusy) begin
        r_end = c;
        break;
      end
      if (mulDone && r_first == 0) r_first = c;
      r_done += int'(mulDone);
      r_en   += int'(mulAccEn);
      r_sel  += int'(mulPassSel);
      r_hs   += int'(mulHiSigned);
      r_eo   |= int'(mulEarlyOut);
      tick();
    end
    mulStart = 0; wbHold = 0; exeFlush = 0;
    if (r_end == 0) chk("busy_timeout", 0, 1);
  endtask

  initial begin
    #200000;
    $display("FAIL global_timeout");
    $fatal(1, "timeout");
  end

  initial begin
    #3;
    chk("reset_outs", {mulBusy, mulPassSel, mulAccClr, mulAccEn, mulShift16, mulHiSigned,
                       mulDone, mulEarlyOut}, 0);
    tick(); tick();
    rstN = 1;
    tick();

    // Unsigned mullw, B high half zero.
    run_op(2'b00, 0, 1, 0, 0, 0, 0, -1, 0);
    chk("u_early_done_cyc", r_first, EO ? 3 : 5);
    chk("u_early_done_cnt", r_done, 1);
    chk("u_early_en_cnt", r_en, EO ? 1 : 2);
    chk("u_early_sel_cnt", r_sel, EO ? 0 : 2);
    chk("u_early_eo", r_eo, int'(EO));
    chk("u_early_end", r_end, EO ? 4 : 6);

    // Unsigned mullw, non-zero high half.
    run_op(2'b00, 0, 0, 0, 0, 0, 0, -1, 0);
    chk("u_full_done_cyc", r_first, 5);
    chk("u_full_en_cnt", r_en, 2);
    chk("u_full_sel_cnt", r_sel, 2);
    chk("u_full_eo", r_eo, 0);

    // Signed mullw, high half all ones with B[16]=1: redundant sign extension.
    run_op(2'b00, 1, 0, 1, 1, 0, 0, -1, 0);
    chk("s_ones_done_cyc", r_first, EO ? 3 : 5);
    chk("s_ones_eo", r_eo, int'(EO));
    // Same but B[16]=0: high half is not a sign extension.
    run_op(2'b00, 1, 0, 1, 0, 0, 0, -1, 0);
    chk("s_mix_done_cyc", r_first, 5);
    chk("s_mix_hisigned_cnt", r_hs, 2);
    chk("s_mix_eo", r_eo, 0);

    // mulhw never early-outs; re-pulsed start at cycle 2 is ignored.
    run_op(2'b01, 1, 1, 0, 0, 2, 0, -1, 0);
    chk("mulhw_done_cyc", r_first, 5);
    chk("mulhw_end", r_end, 6);
    chk("mulhw_eo", r_eo, 0);
    chk("mulhw_hisigned_cnt", r_hs, 2);
    tick();
    chk("mulhw_repulse_idle", int'(mulBusy), 0);

    // Writeback hold cycles 5-7.
    run_op(2'b00, 0, 0, 0, 0, 0, 5, 7, 0);
    chk("hold_done_cyc", r_first, 5);
    chk("hold_done_cnt", r_done, 4);
    chk("hold_en_cnt", r_en, 2);
    chk("hold_end", r_end, 9);

    // Flush in PASS1 at cycle 3, then an immediate normal op.
    run_op(2'b00, 0, 0, 0, 0, 0, 0, -1, 3);
    chk("flush_done_cnt", r_done, 0);
    chk("flush_en_cnt", r_en, 1);
    chk("flush_end", r_end, 4);
    run_op(2'b00, 0, 0, 0, 0, 0, 0, -1, 0);
    chk("post_flush_done_cyc", r_first, 5);
    chk("post_flush_en_cnt", r_en, 2);

    // Flush in FIN beats wbHold.
    run_op(2'b00, 0, 0, 0, 0, 0, 5, 6, 5);
    chk("fin_flush_done_cnt", r_done, 0);
    chk("fin_flush_end", r_end, 6);

    // Flush in IDLE blocks a coincident start.
    mulStart = 1; exeFlush = 1;
    tick();
    mulStart = 0; exeFlush = 0;
    chk("idle_flush_blocks", int'(mulBusy), 0);
    tick();

    // Asynchronous reset mid-operation.
    mulStart = 1; mulOp = 2'b00; mulSigned = 1; bBytes01Eq0 = 0;
    tick();
    mulStart = 0;
    tick();
    #1;
    chk("pre_reset_busy", int'(mulBusy), 1);
    rstN = 0;
    #1;
    chk("async_reset_outs", {mulBusy, mulPassSel, mulAccClr, mulAccEn, mulShift16, mulHiSigned,
                             mulDone, mulEarlyOut}, 0);
    tick();
    rstN = 1;
    tick();
    chk("post_reset_idle", int'(mulBusy), 0);
    run_op(2'b10, 0, 1, 0, 0, 0, 0, -1, 0);
    chk("mulhwu_done_cyc", r_first, 5);
    chk("mulhwu_hisigned_cnt", r_hs, 0);
    tick();

    $display("[TB] %0d tests run, %0d failed", tests, fails);
    $finish;
  end

endmodule

// File: doc/p405s_mul_pass_seq.md
Name: p405s_mul_pass_seq

Overview:
Sequencer for the 405 execute-stage 32x16 multiplier array. It splits a 32x32 multiply into one or two 16-bit passes over operand B, and uses the zero/one detect flags on B's high half to skip the second pass when that half is redundant (early-out). It drives the array's pass select, accumulator clear/enable and sign controls, and handshakes with decode (start/busy) and writeback (done/hold).

Parameters:
PASS_CYC, 2, array cycles per 16-bit pass; legal range 1..4; 2-bit internal counter.

Ports:
CB  input  1  core clock; all state on rising edge
rstN  input  1  asynchronous active-low reset
mulStart  input  1  request pulse from decode; accepted only in IDLE
mulOp  input  2  00 mullw, 01 mulhw (signed high), 10 mulhwu (unsigned high), 11 reserved (treated as mullw)
mulSigned  input  1  operands signed; captured with mulStart
bBytes01Eq0  input  1  B[0:15] all zeros, from zero/one detect
bBytes01Eq1  input  1  B[0:15] all ones, from zero/one detect
bBit16  input  1  B[16], sign of B low half
exeFlush  input  1  kill in-flight multiply
wbHold  input  1  writeback cannot accept result
mulBusy  output  1  sequencer not idle; decode must stall
mulPassSel  output  1  0 = B[16:31] to array, 1 = B[0:15]
mulAccClr  output  1  clear accumulator
mulAccEn  output  1  load partial product into accumulator
mulShift16  output  1  accumulate pass-1 product shifted left 16
mulHiSigned  output  1  treat B high half as signed in array
mulDone  output  1  result valid in accumulator
mulEarlyOut  output  1  current multiply uses one pass

Behaviour:
- Reset (rstN low, asynchronous): state IDLE, counter 0, captured op/sign/early cleared; all outputs 0.
- States: IDLE, PASS0, PASS1, FIN.
- IDLE: mulStart & ~exeFlush -> PASS0, counter 0. Same edge captures mulOp, mulSigned and the early-out decision:
  - unsigned: early = bBytes01Eq0
  - signed: early = (bBytes01Eq0 & ~bBit16) | (bBytes01Eq1 & bBit16)
  - mulOp 01/10 (high-word result): early forced 0
- PASS0: mulPassSel=0. mulAccClr=1 on first cycle only. mulAccEn=1 on last cycle (counter = PASS_CYC-1). Counter increments each cycle. After the last cycle: early -> FIN, else -> PASS1 with counter 0.
- PASS1: mulPassSel=1, mulShift16=1, mulHiSigned=captured sign. mulAccEn=1 on last cycle. After the last cycle -> FIN.
- FIN: mulDone=1. ~wbHold -> IDLE; wbHold -> stay in FIN with mulDone held high and accumulator untouched (mulAccEn=0).
- mulBusy=1 in PASS0, PASS1 and FIN. It is combinational from state, so decode sees it the cycle after the start edge. mulStart while busy is ignored.
- mulEarlyOut = captured early, valid PASS0..FIN; 0 in IDLE.
- Latency from the start edge to mulDone rising: PASS_CYC+1 cycles with early-out, 2*PASS_CYC+1 cycles without.
- exeFlush: in any non-IDLE state -> IDLE next edge. No mulDone, no further mulAccEn; captured fields cleared. exeFlush in IDLE blocks a coincident mulStart. exeFlush in FIN wins over wbHold.
- Async reset mid-operation aborts immediately, with the same end state as the reset case.
- Control outputs are mutually consistent: mulAccClr and mulAccEn are both 1 only when PASS_CYC=1 on the PASS0 cycle.

Optional Feature:
P405S_MUL_EARLY_OUT_EN. Defined: early-out decision as above. Undefined: early forced 0, every multiply takes two passes, mulEarlyOut tied 0, and the bBytes01Eq0/bBytes01Eq1/bBit16 inputs are unused.

Test Plan:
- PASS_CYC=2, mullw unsigned, bBytes01Eq0=1, start at edge 0 -> mulAccClr@1, mulAccEn@2, mulDone=1 @3 only, mulEarlyOut=1, mulPassSel never 1.
- Same with bBytes01Eq0=0 -> PASS1 cycles 3-4 with mulPassSel=1 and mulShift16=1, mulAccEn@2 and @4, mulDone@5.
- Signed mullw, bBytes01Eq1=1, bBit16=1 -> early-out, done@3. Repeat with bBit16=0 -> two passes, done@5, mulHiSigned=1 in PASS1.
- mulhw with bBytes01Eq0=1 -> no early-out, done@5. mulStart re-pulsed at cycle 2 is ignored.
- wbHold=1 cycles 5-7 on a two-pass op -> mulDone held 5..8, IDLE at 9, no mulAccEn during hold.
- exeFlush at cycle 3 (PASS1) -> IDLE at 4, mulDone never asserts. New mulStart at 4 runs a normal sequence. Compile without the macro -> early cases take 2*PASS_CYC+1.
